cond_exec_ctrl: RTL

//  Conditional-execution and branch sequencing controller for the ARM pipeline. Owns the

---
 rtl/cond_exec_ctrl_pkg.sv | 38 +++
 rtl/cond_exec_ctrl_cond_eval.sv | 38 +++
 rtl/cond_exec_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/cond_exec_ctrl_pkg.sv
// Shared constants for the conditional-execution controller: condition codes,
// status-register bit positions and controller FSM states.
package cond_exec_ctrl_pkg;

  localparam int unsigned COND_LEN   = 4;
  localparam int unsigned STATUS_LEN = 4;

  // Bit positions inside the packed {z,c,n,v} status word
  localparam int unsigned ST_Z = 3;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_V = 0;

  typedef enum logic [COND_LEN-1:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic {
    CEC_RUN   = 1'b0,
    CEC_FLUSH = 1'b1
  } cec_state_e;

endpackage

// File: rtl/cond_exec_ctrl_cond_eval.sv
// Combinational condition evaluator: (4-bit condition, {z,c,n,v} flags) -> pass.
module cond_eval
  import cond_exec_ctrl_pkg::*;
(
  input  logic [COND_LEN-1:0]   cond,
  input  logic [STATUS_LEN-1:0] status,
  output logic                  pass
);

  logic z, c, n, v;

  always_comb begin
    z = status[ST_Z];
    c = status[ST_C];
    n = status[ST_N];
    v = status[ST_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution and branch sequencing controller: owns the status register,
// evaluates the ID condition and drives execute-enable, stall, branch and flush.
module cond_exec_ctrl
  import cond_exec_ctrl_pkg::*;
#(
  parameter int unsigned FWD_FLAGS    = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [COND_LEN-1:0]   id_cond,
  input  logic                  id_is_branch,
  input  logic                  exe_valid,
  input  logic                  exe_s,
  input  logic [STATUS_LEN-1:0] exe_status,
  output logic [STATUS_LEN-1:0] status_q,
  output logic                  id_exec_en,
  output logic                  stall,
  output logic                  branch_taken,
  output logic                  flush,
  output logic [CNT_W-1:0]      cond_fail_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam bit       FWD        = (FWD_FLAGS != 0);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  cec_state_e            state_q, state_d;
  logic [2:0]            fcnt_q, fcnt_d;
  logic [STATUS_LEN-1:0] status_d;
  logic [CNT_W-1:0]      cond_fail_q, cond_fail_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  flag_wr;
  logic [STATUS_LEN-1:0] eff_status;
  logic                  pass;
  logic                  hazard;
  logic                  run;
  logic                  cond_fail_inc;

  assign flag_wr    = exe_valid & exe_s;
  assign eff_status = (FWD && flag_wr) ? exe_status : status_q;

  cond_eval u_cond_eval (
    .cond   (id_cond),
    .status (eff_status),
    .pass   (pass)
  );

  // Without forwarding, any conditional ID instruction behind a flag writer must wait
  assign hazard = !FWD && id_valid && (id_cond != COND_AL) && flag_wr;

  always_comb begin
    run           = (state_q == CEC_RUN) && !rst;
    stall         = run && hazard;
    id_exec_en    = run && id_valid && pass && !hazard;
    branch_taken  = id_exec_en && id_is_branch;
    flush         = (state_q == CEC_FLUSH) && !rst;
    cond_fail_inc = run && id_valid && !hazard && !pass;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      CEC_RUN: begin
        if (branch_taken) begin
          state_d = CEC_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      CEC_FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = CEC_RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = CEC_RUN;
    endcase
  end

  always_comb begin
    status_d    = flag_wr ? exe_status : status_q;
    cond_fail_d = (cond_fail_inc && (cond_fail_q != '1)) ? cond_fail_q + CNT_W'(1) : cond_fail_q;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CEC_RUN;
      fcnt_q      <= '0;
      status_q    <= '0;
      cond_fail_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      status_q    <= status_d;
      cond_fail_q <= cond_fail_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cond_fail_cnt = cond_fail_q;
  assign stall_cnt     = stall_cnt_q;

endmodule
